// File: rtl/control_unit.sv
// Multicycle Moore control FSM for the CPU datapath; BEQ's pcWrite is the one Mealy term (on eq).
// Build option: define INVALID_OPCODE_TRAP_EN to send unknown opcode/funct to the exception path.
module control_unit #(
    parameter int unsigned MEM_WAIT = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       overflow,
    input  logic       eq,
    output logic       pcWrite,
    output logic [1:0] iorD,
    output logic       memCtrl,
    output logic       irWrite,
    output logic       regWrite,
    output logic       regDst,
    output logic       memToReg,
    output logic       regA,
    output logic       regB,
    output logic       aluSrcA,
    output logic [1:0] aluSrcB,
    output logic [2:0] aluCtrl,
    output logic       aluOutWrite,
    output logic [1:0] pcSource,
    output logic       epcWrite
);

    typedef enum logic [3:0] {
        S_RST    = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_EXR    = 4'd3,
        S_WBR    = 4'd4,
        S_EXI    = 4'd5,
        S_WBI    = 4'd6,
        S_ADDR   = 4'd7,
        S_MRD    = 4'd8,
        S_WBL    = 4'd9,
        S_MWR    = 4'd10,
        S_BEQ    = 4'd11,
        S_JMP    = 4'd12,
        S_EXC    = 4'd13,
        S_EXL    = 4'd14
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;

    localparam logic [2:0] ALU_ADD  = 3'b001;
    localparam logic [2:0] ALU_SUB  = 3'b010;
    localparam logic [2:0] ALU_AND  = 3'b011;

    localparam logic [2:0] WAIT_LAST = 3'(MEM_WAIT);

`ifdef INVALID_OPCODE_TRAP_EN
    localparam state_t UNKNOWN_NEXT = S_EXC;
`else
    localparam state_t UNKNOWN_NEXT = S_FETCH;
`endif

    state_t     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic       hold_done_s;

    assign hold_done_s = (cnt_q == WAIT_LAST);

    // State and wait-counter registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_RST;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Counter restarts on every state change so each held state sees 0..MEM_WAIT
    always_comb begin
        cnt_d = cnt_q;
        if (state_d != state_q) begin
            cnt_d = 3'd0;
        end else if (cnt_q != 3'd7) begin
            cnt_d = cnt_q + 3'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RST:    state_d = S_FETCH;
            S_FETCH: begin
                if (hold_done_s) begin
                    state_d = S_DECODE;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE: begin
                        if ((funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_AND)) begin
                            state_d = S_EXR;
                        end else begin
                            state_d = UNKNOWN_NEXT;
                        end
                    end
                    OP_ADDI:      state_d = S_EXI;
                    OP_LW, OP_SW: state_d = S_ADDR;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_J:         state_d = S_JMP;
                    default:      state_d = UNKNOWN_NEXT;
                endcase
            end
            S_EXR: begin
                // AND cannot overflow, so its flag is ignored
                if (overflow && (funct != FN_AND)) begin
                    state_d = S_EXC;
                end else begin
                    state_d = S_WBR;
                end
            end
            S_EXI: begin
                if (overflow) begin
                    state_d = S_EXC;
                end else begin
                    state_d = S_WBI;
                end
            end
            S_ADDR: begin
                case (opcode)
                    OP_LW:   state_d = S_MRD;
                    OP_SW:   state_d = S_MWR;
                    default: state_d = S_FETCH;
                endcase
            end
            S_MRD: begin
                if (hold_done_s) begin
                    state_d = S_WBL;
                end else begin
                    state_d = S_MRD;
                end
            end
            S_EXC: begin
                if (hold_done_s) begin
                    state_d = S_EXL;
                end else begin
                    state_d = S_EXC;
                end
            end
            S_WBR, S_WBI, S_WBL, S_MWR, S_BEQ, S_JMP, S_EXL: state_d = S_FETCH;
            default:  state_d = S_RST;
        endcase
    end

    // Control word decode from the current state
    always_comb begin
        pcWrite     = 1'b0;
        iorD        = 2'd0;
        memCtrl     = 1'b0;
        irWrite     = 1'b0;
        regWrite    = 1'b0;
        regDst      = 1'b0;
        memToReg    = 1'b0;
        regA        = 1'b0;
        regB        = 1'b0;
        aluSrcA     = 1'b0;
        aluSrcB     = 2'd0;
        aluCtrl     = 3'b000;
        aluOutWrite = 1'b0;
        pcSource    = 2'd0;
        epcWrite    = 1'b0;
        case (state_q)
            S_FETCH: begin
                iorD = 2'd0;
                if (hold_done_s) begin
                    irWrite  = 1'b1;
                    pcWrite  = 1'b1;
                    aluSrcB  = 2'd1;
                    aluCtrl  = ALU_ADD;
                    pcSource = 2'd0;
                end else begin
                    irWrite  = 1'b0;
                end
            end
            S_DECODE: begin
                regA        = 1'b1;
                regB        = 1'b1;
                aluSrcB     = 2'd3;
                aluCtrl     = ALU_ADD;
                aluOutWrite = 1'b1;
            end
            S_EXR: begin
                aluSrcA     = 1'b1;
                aluOutWrite = 1'b1;
                case (funct)
                    FN_SUB:  aluCtrl = ALU_SUB;
                    FN_AND:  aluCtrl = ALU_AND;
                    default: aluCtrl = ALU_ADD;
                endcase
            end
            S_WBR: begin
                regWrite = 1'b1;
                regDst   = 1'b1;
            end
            S_EXI, S_ADDR: begin
                aluSrcA     = 1'b1;
                aluSrcB     = 2'd2;
                aluCtrl     = ALU_ADD;
                aluOutWrite = 1'b1;
            end
            S_WBI:    regWrite = 1'b1;
            S_MRD:    iorD = 2'd1;
            S_WBL: begin
                regWrite = 1'b1;
                memToReg = 1'b1;
            end
            S_MWR: begin
                iorD    = 2'd1;
                memCtrl = 1'b1;
            end
            S_BEQ: begin
                aluSrcA  = 1'b1;
                aluCtrl  = ALU_SUB;
                pcSource = 2'd1;
                pcWrite  = eq;
            end
            S_JMP: begin
                pcSource = 2'd2;
                pcWrite  = 1'b1;
            end
            S_EXC: begin
                // PC was already advanced in FETCH; EPC captures PC-4
                aluSrcB  = 2'd1;
                aluCtrl  = ALU_SUB;
                epcWrite = 1'b1;
                iorD     = 2'd3;
            end
            S_EXL: begin
                pcSource = 2'd3;
                pcWrite  = 1'b1;
            end
            default: pcWrite = 1'b0;
        endcase
    end

endmodule
